// File: rtl/fifo_rd_stream_if.sv
// FIFO read port and valid/ready output stream of the drain engine.
// The master modport is the drain engine's view.
interface fifo_rd_stream_if #(
    parameter int F_WIDTH = 32,
    parameter int P_N     = 4
);
    logic               fifo_empty;
    logic [P_N:0]       fifo_data_avail;
    logic [F_WIDTH-1:0] fifo_rd_data;
    logic               fifo_rd_en;
    logic               m_valid;
    logic               m_ready;
    logic [F_WIDTH-1:0] m_data;
    logic               m_last;

    modport master (
        input  fifo_empty, fifo_data_avail, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data_avail, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
// It runs in continuous stream mode or in whole-burst mode with an m_last tag.
module fifo_rd_stream #(
    parameter int F_WIDTH = 32,
    parameter int F_DEPTH = 9,
    parameter int P_N     = $clog2(F_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             burst_mode,
    input  logic [P_N:0]     burst_len,
    fifo_rd_stream_if.master bus,
    output logic             busy,
    output logic [15:0]      burst_cnt
);
    localparam logic [P_N:0] DEPTH_C = (P_N+1)'(F_DEPTH);
    localparam logic [P_N:0] ONE_C   = (P_N+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        BURST  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state_r;
    logic [P_N:0]       issue_rem_r;
    logic               from_burst_r;
    logic               busy_r;
    logic               pend_r;
    logic               pend_last_r;
    logic [1:0]         occ_r;
    logic               valid_r;
    logic [F_WIDTH-1:0] ent0_r;
    logic [F_WIDTH-1:0] ent1_r;
    logic               last0_r;
    logic               last1_r;
    logic [15:0]        burst_cnt_r;

    logic [P_N:0]       len_eff_s;
    logic               want_read_s;
    logic               pop_s;
    logic [2:0]         inflight_s;
    logic               rd_en_s;
    logic               tag_s;
    logic [1:0]         occ_nxt_s;

    // Burst length clamp, read request and credit check.
    always_comb begin
        len_eff_s   = burst_len;
        want_read_s = 1'b0;
        if (burst_len > DEPTH_C) begin
            len_eff_s = DEPTH_C;
        end else begin
            len_eff_s = burst_len;
        end
        case (state_r)
            STREAM:  want_read_s = ~burst_mode;
            BURST:   want_read_s = (issue_rem_r != '0);
            default: want_read_s = 1'b0;
        endcase
        pop_s      = valid_r & bus.m_ready;
        // Words already owed to the buffer: resident plus in flight, minus the one leaving now.
        inflight_s = {1'b0, occ_r} + {2'b00, pend_r} - {2'b00, pop_s};
        rd_en_s    = want_read_s & ~bus.fifo_empty & (inflight_s < 3'd2) & ~rst;
        tag_s      = rd_en_s & (state_r == BURST) & (issue_rem_r == ONE_C);
    end

    // Next buffer occupancy from arriving and departing words.
    always_comb begin
        occ_nxt_s = occ_r;
        if (pend_r && !pop_s) begin
            occ_nxt_s = occ_r + 2'd1;
        end else if (!pend_r && pop_s) begin
            occ_nxt_s = occ_r - 2'd1;
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Mode state machine and burst issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            issue_rem_r  <= '0;
            from_burst_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!burst_mode) begin
                        state_r <= STREAM;
                        busy_r  <= 1'b1;
                    end else if ((len_eff_s != '0) && (bus.fifo_data_avail >= len_eff_s)) begin
                        state_r     <= BURST;
                        issue_rem_r <= len_eff_s;
                        busy_r      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (burst_mode) begin
                        state_r      <= DRAIN;
                        from_burst_r <= 1'b0;
                    end
                end
                BURST: begin
                    if (rd_en_s) begin
                        issue_rem_r <= issue_rem_r - ONE_C;
                        if (issue_rem_r == ONE_C) begin
                            state_r      <= DRAIN;
                            from_burst_r <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((occ_r == 2'd0) && !pend_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Skid buffer: head in entry 0, arriving words land behind whatever survives the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
            occ_r       <= 2'd0;
            valid_r     <= 1'b0;
            ent0_r      <= '0;
            ent1_r      <= '0;
            last0_r     <= 1'b0;
            last1_r     <= 1'b0;
            burst_cnt_r <= 16'd0;
        end else begin
            pend_r      <= rd_en_s;
            pend_last_r <= tag_s;
            occ_r       <= occ_nxt_s;
            valid_r     <= (occ_nxt_s != 2'd0);
            case ({pend_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        ent0_r  <= bus.fifo_rd_data;
                        last0_r <= pend_last_r;
                    end else begin
                        ent1_r  <= bus.fifo_rd_data;
                        last1_r <= pend_last_r;
                    end
                end
                2'b01: begin
                    ent0_r  <= ent1_r;
                    last0_r <= last1_r;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        ent0_r  <= bus.fifo_rd_data;
                        last0_r <= pend_last_r;
                    end else begin
                        ent0_r  <= ent1_r;
                        last0_r <= last1_r;
                        ent1_r  <= bus.fifo_rd_data;
                        last1_r <= pend_last_r;
                    end
                end
                default: begin
                    ent0_r <= ent0_r;
                end
            endcase
            if (pop_s && last0_r && from_burst_r) begin
                burst_cnt_r <= burst_cnt_r + 16'd1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = valid_r;
    assign bus.m_data     = ent0_r;
    assign bus.m_last     = last0_r;
    assign busy           = busy_r;
    assign burst_cnt      = burst_cnt_r;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: behavioural FIFO, stream monitor and a queue-based word/last model.
module tb_fifo_rd_stream;
    localparam int F_WIDTH = 32;
    localparam int F_DEPTH = 9;
    localparam int P_N     = $clog2(F_DEPTH);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fifo_rst = 1'b1;
    logic               burst_mode = 1'b0;
    logic [P_N:0]       burst_len = '0;
    logic               busy;
    logic [15:0]        burst_cnt;
    logic               wr_en = 1'b0;
    logic [F_WIDTH-1:0] wr_data = '0;

    int checks = 0;
    int failures = 0;

    logic [F_WIDTH-1:0] mem_q[$];
    logic [F_WIDTH-1:0] exp_q[$];
    logic [F_WIDTH-1:0] rcv_data[$];
    logic               rcv_last[$];
    int issued = 0, accepted = 0;
    int empty_viol = 0, stall_viol = 0, occ_viol = 0, rst_viol = 0;
    logic               stalled_prev = 1'b0;
    logic [F_WIDTH-1:0] prev_data = '0;

    fifo_rd_stream_if #(.F_WIDTH(F_WIDTH), .P_N(P_N)) bus ();

    fifo_rd_stream #(.F_WIDTH(F_WIDTH), .F_DEPTH(F_DEPTH), .P_N(P_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .burst_mode (burst_mode),
        .burst_len  (burst_len),
        .bus        (bus),
        .busy       (busy),
        .burst_cnt  (burst_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO with registered read data and registered status.
    always @(posedge clk) begin
        logic [F_WIDTH-1:0] d;
        if (fifo_rst) begin
            mem_q.delete();
            bus.fifo_rd_data <= '0;
        end else begin
            if (bus.fifo_rd_en && mem_q.size() > 0) begin
                d = mem_q.pop_front();
                bus.fifo_rd_data <= d;
            end
            if (wr_en && mem_q.size() < F_DEPTH) mem_q.push_back(wr_data);
        end
        bus.fifo_empty      <= (mem_q.size() == 0);
        bus.fifo_data_avail <= (P_N+1)'(mem_q.size());
    end

    // Stream monitor: records accepted words and protocol violations.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.fifo_rd_en) rst_viol++;
            issued = 0;
            accepted = 0;
            stalled_prev = 1'b0;
        end else begin
            if (bus.fifo_rd_en && bus.fifo_empty) empty_viol++;
            if (stalled_prev && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol++;
            if (bus.m_valid && bus.m_ready) begin
                rcv_data.push_back(bus.m_data);
                rcv_last.push_back(bus.m_last);
                accepted++;
            end
            if (bus.fifo_rd_en) issued++;
            if (issued - accepted > 2) occ_viol++;
            stalled_prev = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic full_reset();
        rst = 1'b1;
        fifo_rst = 1'b1;
        wr_en = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        fifo_rst = 1'b0;
        exp_q.delete();
        rcv_data.delete();
        rcv_last.delete();
    endtask

    task automatic write_word(input logic [F_WIDTH-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // rmode: 0 always ready, 1 random, 2 pattern 1,0,0
    task automatic run_until(input int n, input int budget, input int rmode);
        int c = 0;
        while (rcv_data.size() < n && c < budget) begin
            case (rmode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (c % 3 == 0);
            endcase
            tick();
            c++;
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        full_reset();
        burst_mode = 1'b0;
        for (int i = 0; i < 7; i++) write_word(32'hA000_0000 + 32'(i));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en_async got=%b want=0", bus.fifo_rd_en);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 ||
                bus.m_last !== 1'b0 || busy !== 1'b0 || burst_cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset_values cyc=%0d got rd_en=%b valid=%b data=%h last=%b busy=%b cnt=%0d want all 0",
                         k, bus.fifo_rd_en, bus.m_valid, bus.m_data, bus.m_last, busy, burst_cnt);
            end
        end
        checks++;
        if (bus.fifo_data_avail !== 5'(5)) begin
            failures++;
            $display("FAIL reset_fifo_level got=%0d want=5", bus.fifo_data_avail);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        tick();
        rst = 1'b0;
        run_until(5, 40, 0);
        checks++;
        if (rcv_data.size() != 5) begin
            failures++;
            $display("FAIL reset_resume_count got=%0d want=5", rcv_data.size());
        end
        for (int i = 0; i < rcv_data.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rcv_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_resume_data idx=%0d got=%h want=%h", i, rcv_data[i], exp_q[i]);
            end
        end
        checks++;
        if (rst_viol != 0) begin
            failures++;
            $display("FAIL rd_en_in_reset got=%0d want=0", rst_viol);
        end
    endtask

    task automatic test_stream();
        full_reset();
        burst_mode = 1'b0;
        for (int i = 1; i <= 9; i++) write_word(F_WIDTH'(i));
        bus.m_ready = 1'b1;
        rst = 1'b0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            checks++;
            if (bus.m_valid !== (j >= 3 && j <= 11)) begin
                failures++;
                $display("FAIL stream_valid j=%0d got=%b want=%b", j, bus.m_valid, (j >= 3 && j <= 11));
            end else if (j >= 3 && j <= 11 && (bus.m_data !== F_WIDTH'(j - 2) || bus.m_last !== 1'b0)) begin
                failures++;
                $display("FAIL stream_data j=%0d got=%h/%b want=%h/0", j, bus.m_data, bus.m_last, j - 2);
            end
        end
        checks++;
        if (empty_viol != 0) begin
            failures++;
            $display("FAIL stream_rd_when_empty got=%0d want=0", empty_viol);
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        int written = 0;
        full_reset();
        burst_mode = 1'b0;
        rst = 1'b0;
        while (rcv_data.size() < 40 && c < 600) begin
            bus.m_ready = (c < 60) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (written < 40 && bus.fifo_data_avail < F_DEPTH && $urandom_range(0, 3) != 0) begin
                wr_en = 1'b1;
                wr_data = $urandom;
                exp_q.push_back(wr_data);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            c++;
        end
        wr_en = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (rcv_data.size() != 40) begin
            failures++;
            $display("FAIL bp_count got=%0d want=40", rcv_data.size());
        end
        for (int i = 0; i < rcv_data.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rcv_data[i] !== exp_q[i] || rcv_last[i] !== 1'b0) begin
                failures++;
                $display("FAIL bp_data idx=%0d got=%h/%b want=%h/0", i, rcv_data[i], rcv_last[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_viol != 0 || occ_viol != 0 || empty_viol != 0) begin
            failures++;
            $display("FAIL bp_protocol got stall=%0d occ=%0d empty=%0d want 0/0/0", stall_viol, occ_viol, empty_viol);
        end
    endtask

    task automatic test_burst_gating();
        full_reset();
        burst_mode = 1'b1;
        burst_len = (P_N+1)'(4);
        bus.m_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) write_word($urandom);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL gate_idle cyc=%0d got busy=%b rd_en=%b want 0/0", i, busy, bus.fifo_rd_en);
            end
            tick();
        end
        write_word($urandom);
        run_until(4, 60, 1);
        checks++;
        if (rcv_data.size() != 4) begin
            failures++;
            $display("FAIL gate_count got=%0d want=4", rcv_data.size());
        end
        for (int i = 0; i < rcv_data.size() && i < 4; i++) begin
            checks++;
            if (rcv_data[i] !== exp_q[i] || rcv_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL gate_data idx=%0d got=%h/%b want=%h/%b", i, rcv_data[i], rcv_last[i], exp_q[i], (i == 3));
            end
        end
        checks++;
        if (burst_cnt !== 16'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gate_cnt got cnt=%0d busy=%b want 1/0", burst_cnt, busy);
        end
    endtask

    task automatic test_clamp_zero();
        logic [P_N:0] len_req;
        int len_eff;
        full_reset();
        len_req = (P_N+1)'(12);
        len_eff = (int'(len_req) < F_DEPTH) ? int'(len_req) : F_DEPTH;
        burst_mode = 1'b1;
        burst_len = len_req;
        rst = 1'b0;
        for (int i = 0; i < F_DEPTH - 1; i++) write_word($urandom);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clamp_wait got busy=%b want=0", busy);
        end
        write_word($urandom);
        run_until(len_eff, 100, 1);
        checks++;
        if (rcv_data.size() != len_eff) begin
            failures++;
            $display("FAIL clamp_count got=%0d want=%0d", rcv_data.size(), len_eff);
        end
        for (int i = 0; i < rcv_data.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rcv_data[i] !== exp_q[i] || rcv_last[i] !== (i == len_eff - 1)) begin
                failures++;
                $display("FAIL clamp_data idx=%0d got=%h/%b want=%h/%b", i, rcv_data[i], rcv_last[i], exp_q[i], (i == len_eff - 1));
            end
        end
        checks++;
        if (burst_cnt !== 16'd1 || stall_viol != 0 || occ_viol != 0) begin
            failures++;
            $display("FAIL clamp_status got cnt=%0d stall=%0d occ=%0d want 1/0/0", burst_cnt, stall_viol, occ_viol);
        end
        burst_len = '0;
        for (int i = 0; i < 5; i++) write_word($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL zero_idle cyc=%0d got busy=%b rd_en=%b want 0/0", i, busy, bus.fifo_rd_en);
            end
            tick();
        end
        checks++;
        if (rcv_data.size() != len_eff) begin
            failures++;
            $display("FAIL zero_no_output got=%0d want=%0d", rcv_data.size(), len_eff);
        end
    endtask

    task automatic test_mode_switch();
        logic exp_last[$];
        full_reset();
        burst_mode = 1'b0;
        for (int i = 0; i < 8; i++) write_word($urandom);
        bus.m_ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.fifo_data_avail !== 5'(6) || rcv_data.size() != 0) begin
            failures++;
            $display("FAIL switch_stall got level=%0d out=%0d want 6/0", bus.fifo_data_avail, rcv_data.size());
        end
        burst_mode = 1'b1;
        burst_len = (P_N+1)'(3);
        // two stream words, then back-to-back bursts of 3 from the remaining 6
        for (int i = 0; i < 8; i++) exp_last.push_back(i == 4 || i == 7);
        run_until(8, 80, 0);
        checks++;
        if (rcv_data.size() != 8) begin
            failures++;
            $display("FAIL switch_count got=%0d want=8", rcv_data.size());
        end
        for (int i = 0; i < rcv_data.size() && i < 8; i++) begin
            checks++;
            if (rcv_data[i] !== exp_q[i] || rcv_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL switch_data idx=%0d got=%h/%b want=%h/%b", i, rcv_data[i], rcv_last[i], exp_q[i], exp_last[i]);
            end
        end
        checks++;
        if (burst_cnt !== 16'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL switch_status got cnt=%0d busy=%b want 2/0", burst_cnt, busy);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_burst_gating();
        test_clamp_zero();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
